// File: rtl/generic_sram_pkg.sv
// generic_sram_pkg
//   Shared types and address-split helpers for the banked SRAM.
//   clear_state_e : clear-engine FSM states
//   row_bits      : row address width inside one bank
//   addr_bits     : full request address width (bank + row)
//   bank_bits     : bank-select field width (0 when there is a single bank)
//   bank_sel_bits : storage width for a bank index (at least 1)
package generic_sram_pkg;

    typedef enum logic {
        IDLE,
        CLEARING
    } clear_state_e;

    function automatic int unsigned row_bits(input int unsigned rows);
        return $clog2(rows);
    endfunction

    function automatic int unsigned addr_bits(input int unsigned banks, input int unsigned rows);
        return $clog2(banks * rows);
    endfunction

    function automatic int unsigned bank_bits(input int unsigned banks, input int unsigned rows);
        return addr_bits(banks, rows) - row_bits(rows);
    endfunction

    function automatic int unsigned bank_sel_bits(input int unsigned banks, input int unsigned rows);
        return (bank_bits(banks, rows) == 0) ? 1 : bank_bits(banks, rows);
    endfunction

endpackage

// File: rtl/generic_sram_bank.sv
// generic_sram_bank
//   Behavioural single-port bank; the unit replaced by a foundry macro.
//   CLK  in   clock
//   ce   in   bank enable
//   we   in   1=write, 0=read (when ce)
//   addr in   row address
//   d    in   write data
//   m    in   write mask, 1=overwrite bit
//   q    out  registered read data, updated only by reads
module generic_sram_bank
    import generic_sram_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ROWS  = 1024
) (
    input  logic                     CLK,
    input  logic                     ce,
    input  logic                     we,
    input  logic [$clog2(ROWS)-1:0]  addr,
    input  logic [WIDTH-1:0]         d,
    input  logic [WIDTH-1:0]         m,
    output logic [WIDTH-1:0]         q
);

    logic [WIDTH-1:0] mem [ROWS];

    always_ff @(posedge CLK) begin
        if (ce) begin
            if (we) begin
                mem[addr] <= (d & m) | (mem[addr] & ~m);
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/generic_banked_sram.sv
// generic_banked_sram
//   Single-port banked SRAM with valid/ready requests, bit-masked writes,
//   configurable read latency and a zero-fill clear engine.
//   CLK        in   clock
//   RST_N      in   asynchronous active-low reset
//   REQ_VALID  in   request present
//   REQ_READY  out  request can be accepted this cycle
//   REQ_WE     in   1=write, 0=read
//   REQ_ADDR   in   {bank, row}
//   REQ_D      in   write data
//   REQ_M      in   write mask, 1=overwrite bit
//   RSP_VALID  out  one-cycle read-data pulse
//   RSP_Q      out  read data, held until the next RSP_VALID
//   CLEAR      in   start zero-fill sweep
//   BUSY       out  sweep in progress
module generic_banked_sram
    import generic_sram_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned ROWS_PER_BANK  = 1024,
    parameter int unsigned NUM_BANKS      = 4,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                                         CLK,
    input  logic                                         RST_N,
    input  logic                                         REQ_VALID,
    output logic                                         REQ_READY,
    input  logic                                         REQ_WE,
    input  logic [$clog2(NUM_BANKS*ROWS_PER_BANK)-1:0]   REQ_ADDR,
    input  logic [WIDTH-1:0]                             REQ_D,
    input  logic [WIDTH-1:0]                             REQ_M,
    output logic                                         RSP_VALID,
    output logic [WIDTH-1:0]                             RSP_Q,
    input  logic                                         CLEAR,
    output logic                                         BUSY
);

    localparam int unsigned AW  = addr_bits(NUM_BANKS, ROWS_PER_BANK);
    localparam int unsigned RW  = row_bits(ROWS_PER_BANK);
    localparam int unsigned BW  = bank_bits(NUM_BANKS, ROWS_PER_BANK);
    localparam int unsigned BIW = bank_sel_bits(NUM_BANKS, ROWS_PER_BANK);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS_PER_BANK - 1);

    clear_state_e     state;
    logic [RW-1:0]    cnt;
    logic             busy_q;
    logic             ready_q;
    logic             sweep_we;
    logic             acc;
    logic             oor;
    logic [BIW-1:0]   bank_idx;
    logic [RW-1:0]    row;

    logic [NUM_BANKS-1:0] bank_ce;
    logic                 bank_we;
    logic [RW-1:0]        bank_addr;
    logic [WIDTH-1:0]     bank_d;
    logic [WIDTH-1:0]     bank_m;
    logic [WIDTH-1:0]     bank_q [NUM_BANKS];

    logic             s1_v;
    logic             zero1;
    logic [BIW-1:0]   sel1;
    logic [WIDTH-1:0] s1_d;

    assign REQ_READY = ready_q & ~CLEAR;
    assign BUSY      = busy_q;
    assign acc       = REQ_VALID & REQ_READY;
    assign row       = REQ_ADDR[RW-1:0];

    generate
        if (NUM_BANKS == 1) begin : g_one_bank
            assign bank_idx = '0;
            assign oor      = 1'b0;
        end else begin : g_multi_bank
            assign bank_idx = REQ_ADDR[AW-1:RW];
            if ((1 << BW) == NUM_BANKS) begin : g_pow2
                assign oor = 1'b0;
            end else begin : g_npow2
                assign oor = (bank_idx >= BIW'(NUM_BANKS));
            end
        end
    endgenerate

    // Clear engine. Leaving reset in CLEARING, busy_q is still 0, so the
    // first cycle only arms the sweep; BUSY then covers exactly the
    // ROWS_PER_BANK write cycles, the same as a CLEAR-initiated sweep.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEARING : IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CLEAR) begin
                        state   <= CLEARING;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                CLEARING: begin
                    if (!busy_q) begin
                        busy_q <= 1'b1;
                    end else if (cnt == ROW_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + RW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_we = (state == CLEARING) & busy_q;

    always_comb begin
        bank_we   = sweep_we | REQ_WE;
        bank_addr = sweep_we ? cnt : row;
        bank_d    = sweep_we ? '0 : REQ_D;
        bank_m    = sweep_we ? '1 : REQ_M;
        bank_ce   = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            bank_ce[i] = sweep_we | (acc & ~oor & (bank_idx == BIW'(i)));
        end
    end

    generate
        for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
            generic_sram_bank #(
                .WIDTH (WIDTH),
                .ROWS  (ROWS_PER_BANK)
            ) u_bank (
                .CLK   (CLK),
                .ce    (bank_ce[g]),
                .we    (bank_we),
                .addr  (bank_addr),
                .d     (bank_d),
                .m     (bank_m),
                .q     (bank_q[g])
            );
        end
    endgenerate

    // First read stage: bank output registers plus the captured select.
    // zero1 resets to 1 so the mux yields 0 without resetting the banks,
    // and it forces 0 for out-of-range reads.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_v  <= 1'b0;
            zero1 <= 1'b1;
            sel1  <= '0;
        end else begin
            s1_v <= acc & ~REQ_WE;
            if (acc & ~REQ_WE) begin
                sel1  <= bank_idx;
                zero1 <= oor;
            end
        end
    end

    always_comb begin
        s1_d = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (!zero1 && (sel1 == BIW'(i))) begin
                s1_d = bank_q[i];
            end
        end
    end

    generate
        if (READ_LATENCY > 1) begin : g_pipe
            logic             ext_v [READ_LATENCY-1];
            logic [WIDTH-1:0] ext_d [READ_LATENCY-1];

            // Data stages load only with a valid so RSP_Q holds between responses.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    for (int unsigned i = 0; i < READ_LATENCY - 1; i++) begin
                        ext_v[i] <= 1'b0;
                        ext_d[i] <= '0;
                    end
                end else begin
                    ext_v[0] <= s1_v;
                    if (s1_v) begin
                        ext_d[0] <= s1_d;
                    end
                    for (int unsigned i = 1; i < READ_LATENCY - 1; i++) begin
                        ext_v[i] <= ext_v[i-1];
                        if (ext_v[i-1]) begin
                            ext_d[i] <= ext_d[i-1];
                        end
                    end
                end
            end

            assign RSP_VALID = ext_v[READ_LATENCY-2];
            assign RSP_Q     = ext_d[READ_LATENCY-2];
        end else begin : g_nopipe
            assign RSP_VALID = s1_v;
            assign RSP_Q     = s1_d;
        end
    endgenerate

endmodule

// File: tb/tb_generic_banked_sram.sv
// tb_generic_banked_sram
//   Self-checking bench: main instance (2 banks x 8 rows, latency 2) with a
//   reference memory and response scoreboard, plus a 3-bank instance for the
//   out-of-range address behaviour.
module tb_generic_banked_sram;

    localparam int unsigned LAT = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;

    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WE = 1'b0;
    logic [3:0]  REQ_ADDR = '0;
    logic [15:0] REQ_D = '0;
    logic [15:0] REQ_M = '0;
    logic        RSP_VALID;
    logic [15:0] RSP_Q;
    logic        CLEAR = 1'b0;
    logic        BUSY;

    logic        v2 = 1'b0;
    logic        ready2;
    logic        we2 = 1'b0;
    logic [4:0]  a2 = '0;
    logic [15:0] d2 = '0;
    logic [15:0] m2 = '0;
    logic        rv2;
    logic [15:0] q2;
    logic        clear2 = 1'b0;
    logic        busy2;

    always #5 CLK = ~CLK;

    generic_banked_sram #(
        .WIDTH          (16),
        .ROWS_PER_BANK  (8),
        .NUM_BANKS      (2),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WE    (REQ_WE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_D     (REQ_D),
        .REQ_M     (REQ_M),
        .RSP_VALID (RSP_VALID),
        .RSP_Q     (RSP_Q),
        .CLEAR     (CLEAR),
        .BUSY      (BUSY)
    );

    generic_banked_sram #(
        .WIDTH          (16),
        .ROWS_PER_BANK  (8),
        .NUM_BANKS      (3),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1)
    ) dut3 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ_VALID (v2),
        .REQ_READY (ready2),
        .REQ_WE    (we2),
        .REQ_ADDR  (a2),
        .REQ_D     (d2),
        .REQ_M     (m2),
        .RSP_VALID (rv2),
        .RSP_Q     (q2),
        .CLEAR     (clear2),
        .BUSY      (busy2)
    );

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [16];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    // One clock: note acceptance before the edge, then check responses after it.
    task automatic tick();
        exp_t e;
        logic acc;
        @(negedge CLK);
        acc = (REQ_VALID === 1'b1) && (REQ_READY === 1'b1);
        if (acc && REQ_WE) begin
            model[REQ_ADDR] = (REQ_D & REQ_M) | (model[REQ_ADDR] & ~REQ_M);
        end else if (acc) begin
            e.data = model[REQ_ADDR];
            e.due  = cyc + LAT;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing: no RSP_VALID by cycle %0d, required data %h", sb[0].due, sb[0].data);
            void'(sb.pop_front());
        end
        if (RSP_VALID === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: RSP_VALID at cycle %0d with RSP_Q=%h, none required", cyc, RSP_Q);
            end else begin
                e = sb.pop_front();
                if (RSP_Q !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL rsp_data: got %h at cycle %0d, required %h at cycle %0d", RSP_Q, cyc, e.data, e.due);
                end
            end
        end
    endtask

    task automatic idle_in();
        REQ_VALID = 1'b0;
        REQ_WE    = 1'b0;
        CLEAR     = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (REQ_READY !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: REQ_READY=%b, required 1", REQ_READY);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [15:0] m);
        wait_ready();
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b1;
        REQ_ADDR  = a;
        REQ_D     = d;
        REQ_M     = m;
        tick();
        idle_in();
    endtask

    task automatic rd(input logic [3:0] a);
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_ADDR  = a;
        tick();
    endtask

    task automatic drain();
        idle_in();
        repeat (LAT + 2) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rsp_pending: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Counts BUSY-high cycles until BUSY falls, with a cycle bound.
    task automatic count_busy(input string nm, input int required);
        int  n;
        int  guard;
        bit  seen;
        bit  ready_bad;
        n = 0; guard = 0; seen = 0; ready_bad = 0;
        while (guard < 40 && !(seen && BUSY !== 1'b1)) begin
            tick();
            guard++;
            if (BUSY === 1'b1) begin
                seen = 1;
                n++;
                if (REQ_READY !== 1'b0) ready_bad = 1;
            end
        end
        checks++;
        if (n != required) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d, required %0d", nm, n, required);
        end
        checks++;
        if (ready_bad) begin
            errors++;
            $display("FAIL %s_ready_while_busy: REQ_READY was 1 during sweep, required 0", nm);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        checks++;
        if (BUSY !== 1'b0 || REQ_READY !== 1'b0 || RSP_VALID !== 1'b0 || RSP_Q !== 16'h0000) begin
            errors++;
            $display("FAIL %s: BUSY=%b REQ_READY=%b RSP_VALID=%b RSP_Q=%h, required 0 0 0 0000",
                     nm, BUSY, REQ_READY, RSP_VALID, RSP_Q);
        end
    endtask

    task automatic test_reset();
        idle_in();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset_state");
        RST_N = 1'b1;
        count_busy("reset_sweep", 8);
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        for (int i = 0; i < 16; i++) rd(4'(i));
        drain();
    endtask

    task automatic test_mask();
        wr(4'd3, 16'hA5A5, 16'hFFFF);
        wr(4'd3, 16'h00FF, 16'h0F0F);
        checks++;
        if (model[3] !== 16'hA0AF) begin
            errors++;
            $display("FAIL mask_model: model %h, required A0AF", model[3]);
        end
        rd(4'd3);
        drain();
    endtask

    task automatic test_back_to_back();
        wr(4'd5, 16'h1234, 16'hFFFF);
        wr(4'd13, 16'hBEEF, 16'hFFFF);
        rd(4'd5);
        rd(4'd13);
        rd(4'd5);
        drain();
        repeat (3) tick();
        checks++;
        if (RSP_Q !== 16'h1234 || RSP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL rsp_hold: RSP_Q=%h RSP_VALID=%b, required 1234 0", RSP_Q, RSP_VALID);
        end
    endtask

    task automatic test_reset_mid_sweep();
        wait_ready();
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        repeat (4) tick();
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL midsweep_busy: BUSY=%b, required 1", BUSY);
        end
        RST_N = 1'b0;
        #1;
        check_reset_outputs("midsweep_reset");
        sb.delete();
        repeat (2) tick();
        RST_N = 1'b1;
        count_busy("restart_sweep", 8);
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        rd(4'd5);
        rd(4'd13);
        drain();
    endtask

    task automatic test_clear();
        wr(4'd13, 16'hBEEF, 16'hFFFF);
        rd(4'd13);
        REQ_VALID = 1'b0;
        CLEAR     = 1'b1;
        tick();
        CLEAR = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        count_busy("clear_sweep", 7);
        rd(4'd13);
        drain();
        // CLEAR and a request together while idle
        wait_ready();
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_ADDR  = 4'd5;
        CLEAR     = 1'b1;
        #1;
        checks++;
        if (REQ_READY !== 1'b0) begin
            errors++;
            $display("FAIL clear_vs_req_ready: REQ_READY=%b, required 0", REQ_READY);
        end
        tick();
        idle_in();
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL clear_vs_req_busy: BUSY=%b, required 1", BUSY);
        end
        count_busy("clear_vs_req_sweep", 7);
        drain();
    endtask

    task automatic rd3(input logic [4:0] a, input logic [15:0] exp);
        int n;
        v2  = 1'b1;
        we2 = 1'b0;
        a2  = a;
        tick();
        v2 = 1'b0;
        n = 0;
        while (rv2 !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (rv2 !== 1'b1 || q2 !== exp || n != LAT - 1) begin
            errors++;
            $display("FAIL oob_read@%0d: RSP_VALID=%b RSP_Q=%h after %0d extra cycles, required 1 %h after %0d",
                     a, rv2, q2, n, exp, LAT - 1);
        end
    endtask

    task automatic test_oob();
        logic [4:0] addrs [4];
        int n;
        addrs[0] = 5'd0; addrs[1] = 5'd8; addrs[2] = 5'd16; addrs[3] = 5'd24;
        n = 0;
        while (ready2 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (ready2 !== 1'b1) begin
            errors++;
            $display("FAIL oob_ready: REQ_READY=%b, required 1", ready2);
        end
        v2  = 1'b1;
        we2 = 1'b1;
        a2  = 5'd24;
        d2  = 16'hFFFF;
        m2  = 16'hFFFF;
        tick();
        v2 = 1'b0;
        for (int i = 0; i < 4; i++) rd3(addrs[i], 16'h0000);
        v2  = 1'b1;
        we2 = 1'b1;
        a2  = 5'd16;
        d2  = 16'h5555;
        m2  = 16'hFFFF;
        tick();
        v2 = 1'b0;
        rd3(5'd16, 16'h5555);
        rd3(5'd24, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mask();
        test_back_to_back();
        test_reset_mid_sweep();
        test_clear();
        test_oob();
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
